// File: rtl/text_fetch_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : text_fetch_sched
// Description : Per-scanline greeting/font ROM fetch scheduler that loads
//               glyph rows into the text sprite bank during h-blank.
// Revision    : 1.0 - initial release
// ============================================================================
module text_fetch_sched #(
    parameter int SPR_CNT     = 8,
    parameter int GREET_MSGS  = 32,
    parameter int FONT_HEIGHT = 8,
    parameter int FONT_WIDTH  = 8,
    parameter int NUM_GLYPHS  = 64,
    parameter int CP_START    = 'h20,
    parameter int CP_W        = 7,
    parameter int TXT_SCALY   = 10,
    parameter int TXT_PAUSE   = 80,
    parameter int CORDW       = 16,
    localparam int GREET_AW   = $clog2(GREET_MSGS * 2 * SPR_CNT),
    localparam int FONT_AW    = $clog2(NUM_GLYPHS * FONT_HEIGHT),
    localparam int IDX_W      = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1,
    localparam int MSG_W      = (GREET_MSGS > 1) ? $clog2(GREET_MSGS) : 1
) (
    input  logic                    video_clk_pix,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] row_y0,
    input  logic signed [CORDW-1:0] row_y1,
    output logic [GREET_AW-1:0]     greet_addr,
    input  logic [CP_W-1:0]         greet_data,
    output logic [FONT_AW-1:0]      font_addr,
    input  logic [FONT_WIDTH-1:0]   font_data,
    output logic                    load_valid,
    output logic [IDX_W-1:0]        load_idx,
    output logic [FONT_WIDTH-1:0]   load_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic [MSG_W-1:0]        greeting
);

    localparam int FRM_W = (TXT_PAUSE > 1) ? $clog2(TXT_PAUSE) : 1;
    localparam int GL_W  = (FONT_HEIGHT > 1) ? $clog2(FONT_HEIGHT) : 1;
    localparam int SC_W  = (TXT_SCALY > 1) ? $clog2(TXT_SCALY) : 1;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_FETCH_CP    = 2'd1,
        S_FETCH_GLYPH = 2'd2,
        S_FLUSH       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
    logic [GREET_AW-1:0]   base_q, base_d;
    logic [GREET_AW-1:0]   greet_addr_q, greet_addr_d;
    logic [FONT_AW-1:0]    font_addr_q, font_addr_d;
    logic                  greet_pend_q, greet_pend_d;
    logic [IDX_W-1:0]      greet_pend_idx_q, greet_pend_idx_d;
    logic [CP_W-1:0]       cp_q [SPR_CNT];
    logic [CP_W-1:0]       cp_d [SPR_CNT];
    logic                  load_valid_q, load_valid_d;
    logic [IDX_W-1:0]      load_idx_q, load_idx_d;
    logic [FONT_WIDTH-1:0] load_hold_q, load_hold_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic [FRM_W-1:0]      cnt_frm_q, cnt_frm_d;
    logic [MSG_W-1:0]      greeting_q, greeting_d;
    logic                  row_active_q, row_active_d;
    logic                  row_sel_q, row_sel_d;
    logic [GL_W-1:0]       glyph_line_q, glyph_line_d;
    logic [SC_W-1:0]       scale_cnt_q, scale_cnt_d;

    // Out-of-range code points fall back to glyph 0 (space).
    function automatic logic [FONT_AW-1:0] glyph_addr(input logic [CP_W-1:0] cp,
                                                      input logic [GL_W-1:0] gl);
        logic [31:0] cp_w;
        logic [31:0] gidx;
        cp_w = 32'(cp);
        if (cp_w < 32'(CP_START) || cp_w >= 32'(CP_START + NUM_GLYPHS))
            gidx = '0;
        else
            gidx = cp_w - 32'(CP_START);
        return FONT_AW'(gidx * 32'(FONT_HEIGHT) + 32'(gl));
    endfunction

    always_comb begin
        cnt_frm_d  = cnt_frm_q;
        greeting_d = greeting_q;
        if (frame_start) begin
            if (cnt_frm_q == FRM_W'(TXT_PAUSE - 1)) begin
                cnt_frm_d  = '0;
                greeting_d = (greeting_q == MSG_W'(GREET_MSGS - 1)) ? '0 : greeting_q + 1'b1;
            end else begin
                cnt_frm_d = cnt_frm_q + 1'b1;
            end
        end
    end

    always_comb begin
        row_active_d = row_active_q;
        row_sel_d    = row_sel_q;
        glyph_line_d = glyph_line_q;
        scale_cnt_d  = scale_cnt_q;
        if (line_start) begin
            if (sy == row_y1 || sy == row_y0) begin
                row_active_d = 1'b1;
                row_sel_d    = (sy == row_y1);
                glyph_line_d = '0;
                scale_cnt_d  = '0;
            end else if (row_active_q) begin
                if (scale_cnt_q == SC_W'(TXT_SCALY - 1)) begin
                    scale_cnt_d = '0;
                    if (glyph_line_q == GL_W'(FONT_HEIGHT - 1))
                        row_active_d = 1'b0;
                    else
                        glyph_line_d = glyph_line_q + 1'b1;
                end else begin
                    scale_cnt_d = scale_cnt_q + 1'b1;
                end
            end
        end
    end

    // cp_d bypasses the capture in flight so the first font address can use it.
    always_comb begin
        cp_d = cp_q;
        if (greet_pend_q)
            cp_d[greet_pend_idx_q] = greet_data;
    end

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        base_d           = base_q;
        greet_addr_d     = greet_addr_q;
        font_addr_d      = font_addr_q;
        greet_pend_d     = 1'b0;
        greet_pend_idx_d = idx_q;
        load_valid_d     = 1'b0;
        load_idx_d       = load_idx_q;
        done_d           = 1'b0;
        overrun_d        = overrun_q;
        if (line_start) begin
            // A new line always wins: in-flight reads and loads are dropped.
            if (state_q != S_IDLE)
                overrun_d = 1'b1;
            if (row_active_d) begin
                state_d      = S_FETCH_CP;
                idx_d        = '0;
                base_d       = GREET_AW'(32'(greeting_d) * 32'(2 * SPR_CNT)
                                         + (row_sel_d ? 32'(SPR_CNT) : 32'd0));
                greet_addr_d = base_d;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_FETCH_CP: begin
                    greet_pend_d = 1'b1;
                    if (idx_q == IDX_W'(SPR_CNT - 1)) begin
                        state_d     = S_FETCH_GLYPH;
                        idx_d       = '0;
                        font_addr_d = glyph_addr(cp_d[0], glyph_line_q);
                    end else begin
                        idx_d        = idx_nxt;
                        greet_addr_d = greet_addr_q + 1'b1;
                    end
                end
                S_FETCH_GLYPH: begin
                    load_valid_d = 1'b1;
                    load_idx_d   = idx_q;
                    if (idx_q == IDX_W'(SPR_CNT - 1)) begin
                        state_d = S_FLUSH;
                    end else begin
                        idx_d       = idx_nxt;
                        font_addr_d = glyph_addr(cp_d[idx_nxt], glyph_line_q);
                    end
                end
                S_FLUSH: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign load_data   = load_valid_q ? font_data : load_hold_q;
    assign load_hold_d = load_data;

    always_ff @(posedge video_clk_pix) begin
        if (rst) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            base_q           <= '0;
            greet_addr_q     <= '0;
            font_addr_q      <= '0;
            greet_pend_q     <= 1'b0;
            greet_pend_idx_q <= '0;
            for (int i = 0; i < SPR_CNT; i++)
                cp_q[i] <= '0;
            load_valid_q     <= 1'b0;
            load_idx_q       <= '0;
            load_hold_q      <= '0;
            done_q           <= 1'b0;
            overrun_q        <= 1'b0;
            cnt_frm_q        <= '0;
            greeting_q       <= '0;
            row_active_q     <= 1'b0;
            row_sel_q        <= 1'b0;
            glyph_line_q     <= '0;
            scale_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            base_q           <= base_d;
            greet_addr_q     <= greet_addr_d;
            font_addr_q      <= font_addr_d;
            greet_pend_q     <= greet_pend_d;
            greet_pend_idx_q <= greet_pend_idx_d;
            cp_q             <= cp_d;
            load_valid_q     <= load_valid_d;
            load_idx_q       <= load_idx_d;
            load_hold_q      <= load_hold_d;
            done_q           <= done_d;
            overrun_q        <= overrun_d;
            cnt_frm_q        <= cnt_frm_d;
            greeting_q       <= greeting_d;
            row_active_q     <= row_active_d;
            row_sel_q        <= row_sel_d;
            glyph_line_q     <= glyph_line_d;
            scale_cnt_q      <= scale_cnt_d;
        end
    end

    assign greet_addr = greet_addr_q;
    assign font_addr  = font_addr_q;
    assign load_valid = load_valid_q;
    assign load_idx   = load_idx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign greeting   = greeting_q;

endmodule
`default_nettype wire

// File: tb/tb_text_fetch_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_text_fetch_sched
// Description : Self-checking bench: segment table walk plus corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_fetch_sched;

    localparam int SPR    = 8;
    localparam int MSGS   = 32;
    localparam int FH     = 8;
    localparam int SCALY  = 10;
    localparam int PAUSE  = 3;
    localparam int CPS    = 'h20;
    localparam int NG     = 64;
    localparam int ROW_Y0 = 4;
    localparam int ROW_Y1 = ROW_Y0 + FH * SCALY + 3;
    localparam int NFULL  = 2 * SPR + 3;

    logic               clk = 1'b0;
    logic               rst, frame_start, line_start;
    logic signed [15:0] sy, row_y0, row_y1;
    logic [8:0]         greet_addr, font_addr;
    logic [6:0]         greet_data;
    logic [7:0]         font_data, load_data;
    logic               load_valid, busy, done, overrun;
    logic [2:0]         load_idx;
    logic [4:0]         greeting;

    logic [6:0] greet_mem [512];
    int checks = 0, errors = 0, cyc = 0;
    int exp_greet = 0, exp_cnt = 0;

    typedef struct { int cyc; int idx; int data; } load_t;
    load_t sb[$];
    load_t mon_e;

    typedef struct { int sy_lo; int sy_hi; bit act; int row; int y_base; } seg_t;
    seg_t segs[5];

    text_fetch_sched #(.TXT_PAUSE(PAUSE)) dut (
        .video_clk_pix(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
        .sy(sy), .row_y0(row_y0), .row_y1(row_y1),
        .greet_addr(greet_addr), .greet_data(greet_data),
        .font_addr(font_addr), .font_data(font_data),
        .load_valid(load_valid), .load_idx(load_idx), .load_data(load_data),
        .busy(busy), .done(done), .overrun(overrun), .greeting(greeting)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] font_fn(input int a);
        return 8'((a * 37 + 11) & 'hFF);
    endfunction

    always @(posedge clk) begin
        greet_data <= greet_mem[greet_addr];
        font_data  <= font_fn(int'(font_addr));
    end

    function automatic int exp_faddr(input int cp, input int gl);
        int g;
        g = (cp >= CPS && cp < CPS + NG) ? cp - CPS : 0;
        return (g * FH + gl) % 512;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (load_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: idx %0d data %0d with nothing expected", load_idx, load_data);
            end else begin
                mon_e = sb.pop_front();
                chk("load_cycle", cyc, mon_e.cyc);
                chk("load_idx", int'(load_idx), mon_e.idx);
                chk("load_data", int'(load_data), mon_e.data);
            end
        end
    end

    task automatic frame_model();
        exp_cnt++;
        if (exp_cnt == PAUSE) begin
            exp_cnt   = 0;
            exp_greet = (exp_greet + 1) % MSGS;
        end
    endtask

    // Starts and ends just after a negedge.
    task automatic frame_pulse();
        frame_start = 1'b1;
        frame_model();
        @(negedge clk);
        frame_start = 1'b0;
        chk("greeting", int'(greeting), exp_greet);
    endtask

    // Drives a line_start at the current negedge (cycle T0) and checks T1..Tncyc.
    task automatic do_line(input int sy_i, input bit act, input int row, input int gl,
                           input bit frm, input int ncyc);
        int base, c0;
        int fa[SPR];
        sy          = 16'(sy_i);
        line_start  = 1'b1;
        frame_start = frm;
        if (frm) frame_model();
        c0   = cyc;
        base = exp_greet * 2 * SPR + row * SPR;
        for (int i = 0; i < SPR; i++) begin
            fa[i] = exp_faddr(int'(greet_mem[base + i]), gl);
            if (act && 10 + i <= ncyc)
                sb.push_back('{c0 + 10 + i, i, int'(font_fn(fa[i]))});
        end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                line_start  = 1'b0;
                frame_start = 1'b0;
            end
            chk("busy", int'(busy), int'(act && k <= 2 * SPR + 1));
            chk("done", int'(done), int'(act && k == 2 * SPR + 2));
            if (act && k <= SPR)
                chk("greet_addr", int'(greet_addr), base + k - 1);
            if (act && k > SPR && k <= 2 * SPR)
                chk("font_addr", int'(font_addr), fa[k - SPR - 1]);
            if (act && k == 2 * SPR + 2)
                chk("load_hold", int'(load_data), int'(font_fn(fa[SPR - 1])));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string hello;
        hello       = "HELLO, WORLD! :)";
        rst         = 1'b1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        sy          = '0;
        row_y0      = 16'(ROW_Y0);
        row_y1      = 16'(ROW_Y1);
        for (int a = 0; a < 512; a++)
            greet_mem[a] = 7'(CPS + (a * 7 + 3) % NG);
        for (int i = 0; i < 16; i++)
            greet_mem[i] = 7'(hello[i]);
        greet_mem[16] = 7'h10;
        greet_mem[17] = 7'h7F;
        greet_mem[18] = 7'h5F;
        greet_mem[19] = 7'h60;
        greet_mem[20] = 7'h1F;
        greet_mem[21] = 7'h20;

        segs[0] = '{0,          ROW_Y0 - 1,  1'b0, 0, 0};
        segs[1] = '{ROW_Y0,     ROW_Y0 + 79, 1'b1, 0, ROW_Y0};
        segs[2] = '{ROW_Y0 + 80, ROW_Y1 - 1, 1'b0, 0, 0};
        segs[3] = '{ROW_Y1,     ROW_Y1 + 79, 1'b1, 1, ROW_Y1};
        segs[4] = '{ROW_Y1 + 80, ROW_Y1 + 82, 1'b0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_greet_addr", int'(greet_addr), 0);
        chk("rst_font_addr", int'(font_addr), 0);
        chk("rst_load_valid", int'(load_valid), 0);
        chk("rst_load_idx", int'(load_idx), 0);
        chk("rst_load_data", int'(load_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_greeting", int'(greeting), 0);
        rst = 1'b0;
        @(negedge clk);

        // Every line from 0 past the end of row 1, expectations from the segment table.
        for (int s = 0; s < 5; s++)
            for (int y = segs[s].sy_lo; y <= segs[s].sy_hi; y++)
                do_line(y, segs[s].act, segs[s].row,
                        segs[s].act ? (y - segs[s].y_base) / SCALY : 0,
                        1'b0, segs[s].act ? NFULL : 3);
        chk("walk_overrun", int'(overrun), 0);
        chk("walk_sb_empty", sb.size(), 0);

        // Message 1 carries out-of-range and edge code points.
        repeat (PAUSE) frame_pulse();
        chk("greeting_one", int'(greeting), 1);
        do_line(ROW_Y0, 1'b1, 0, 0, 1'b0, NFULL);

        // Wrap on a frame_start coinciding with a line_start.
        repeat (MSGS * PAUSE - PAUSE - 1) frame_pulse();
        chk("greeting_last", int'(greeting), MSGS - 1);
        do_line(ROW_Y0, 1'b1, 0, 0, 1'b1, NFULL);
        chk("greeting_wrap", int'(greeting), 0);

        // line_start at T5 of an active fetch.
        do_line(ROW_Y0, 1'b1, 0, 0, 1'b0, 5);
        do_line(ROW_Y0 + 1, 1'b1, 0, 0, 1'b0, NFULL);
        chk("overrun_set", int'(overrun), 1);

        // Reset at T12 of an active fetch, with a nonzero greeting.
        repeat (PAUSE) frame_pulse();
        do_line(ROW_Y0, 1'b1, 0, 0, 1'b0, 12);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_greet = 0;
        exp_cnt   = 0;
        chk("rst_mid_load_valid", int'(load_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_greeting", int'(greeting), 0);
        chk("rst_mid_overrun", int'(overrun), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_mid_no_done", int'(done), 0);
            chk("rst_mid_idle", int'(busy), 0);
        end
        do_line(20, 1'b0, 0, 0, 1'b0, 3);
        do_line(ROW_Y0, 1'b1, 0, 0, 1'b0, NFULL);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_fetch_sched.md
# text_fetch_sched

Per-scanline fetch scheduler for the two-row scaled text overlay. It selects the active greeting message and advances it every TXT_PAUSE frames. At each qualifying line start it sequences reads from the greeting ROM and the font ROM for SPR_CNT glyph sprites, then hands each sprite its glyph row through a load strobe. It sits between the two rom_sync instances and the sprite bank, in the video_clk_pix domain. It replaces open-coded sx-compare DMA slot decoding.

## Interface
- SPR_CNT, 8, sprites per text row; greeting length = 2*SPR_CNT
- GREET_MSGS, 32, messages in the greeting ROM
- FONT_HEIGHT, 8, glyph rows
- FONT_WIDTH, 8, glyph row width (bits)
- NUM_GLYPHS, 64, glyphs in the font ROM
- CP_START, 'h20, first code point in the font ROM
- CP_W, 7, code point width
- TXT_SCALY, 10, vertical scale (≥1)
- TXT_PAUSE, 80, frames per message (≥1)
- CORDW, 16, signed coordinate width
- video_clk_pix  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  one-cycle pulse at frame start
- line_start  in  1  one-cycle pulse at line start (in h-blank)
- sy  in  CORDW signed  current line
- row_y0, row_y1  in  CORDW signed  top line of text rows 0/1; row_y1 ≥ row_y0 + FONT_HEIGHT*TXT_SCALY
- greet_addr  out  clog2(GREET_MSGS*2*SPR_CNT)  greeting ROM address
- greet_data  in  CP_W  code point, 1-cycle ROM latency
- font_addr  out  clog2(NUM_GLYPHS*FONT_HEIGHT)  font ROM address
- font_data  in  FONT_WIDTH  glyph row, 1-cycle ROM latency
- load_valid  out  1  glyph row for sprite load_idx is on load_data
- load_idx  out  clog2(SPR_CNT)  target sprite
- load_data  out  FONT_WIDTH  glyph row bits
- busy  out  1  fetch sequence in progress
- done  out  1  one-cycle pulse after the last load of a line
- overrun  out  1  sticky: line_start arrived while busy
- greeting  out  clog2(GREET_MSGS)  current message index

## Operation
- Message selection: frame counter cnt_frm increments on frame_start. When frame_start arrives with cnt_frm == TXT_PAUSE-1, cnt_frm goes to 0 and greeting goes to greeting+1, wrapping GREET_MSGS-1 → 0. The message changes exactly every TXT_PAUSE frames and never mid-frame.
- Row tracking: at line_start, a match of sy == row_y1 starts row 1; otherwise sy == row_y0 starts row 0. Starting a row sets row_sel, glyph_line=0, scale_cnt=0, and marks the line active.
- On later line_starts of an active row, scale_cnt increments. When scale_cnt wraps at TXT_SCALY-1, glyph_line increments. When glyph_line == FONT_HEIGHT-1 and scale_cnt == TXT_SCALY-1, the next line_start deactivates the row unless it also matches a row start.
- FSM states: IDLE, FETCH_CP, FETCH_GLYPH, FLUSH.
  - IDLE → FETCH_CP on line_start when the line is active.
  - FETCH_CP: issue greet_addr = greeting*2*SPR_CNT + row_sel*SPR_CNT + i for i = 0..SPR_CNT-1, one per cycle. Capture greet_data into cp[i] one cycle later.
  - FETCH_GLYPH: issue font_addr = (cp[i]-CP_START)*FONT_HEIGHT + glyph_line for i = 0..SPR_CNT-1, one per cycle. The glyph index is forced to 0 (space) when cp[i] < CP_START or cp[i] ≥ CP_START+NUM_GLYPHS.
  - FLUSH: last font read returns, then → IDLE.
- Loads: font_data returned for slot i drives load_valid=1, load_idx=i, load_data=font_data. Otherwise load_valid=0 and load_data holds its last value.
- Inactive lines: no ROM reads and no loads.
- line_start while busy: set overrun, abort, and restart the sequence for the new line (or go IDLE if the new line is inactive).
- Arithmetic: addresses are computed at full width and truncated to the port width. greeting wraps modulo GREET_MSGS.

## Timing
- Take line_start at cycle T0.
  - greet_addr slot i is valid at T1+i; cp[i] is captured at T2+i.
  - font_addr slot i is valid at T(SPR_CNT+1)+i.
  - load for sprite i is at T(SPR_CNT+2)+i; the last load is at T(2*SPR_CNT+1).
  - done pulses at T(2*SPR_CNT+2).
  - busy is high T1..T(2*SPR_CNT+1).
- Default (SPR_CNT=8): loads T10..T17, done at T18. The h-blank budget is ≥ 2*SPR_CNT+3 cycles.
- frame_start and line_start in the same cycle: both are handled; the message update applies to fetches that start afterwards.
- Reset values: greet_addr=0, font_addr=0, load_valid=0, load_idx=0, load_data=0, busy=0, done=0, overrun=0, greeting=0. Internally: cnt_frm=0, row inactive, FSM IDLE. Reset mid-sequence aborts with no further loads.

## Test plan
- Reset, then sy=row_y0 line_start, greeting 0, ROM cp "HELLO..." → greet_addr 0..7 at T1..T8; load_idx 0..7 at T10..T17 with font rows at glyph_line 0; done at T18.
- Row 1, line row_y1 + 3*TXT_SCALY + 2 → greet_addr base 8..15, font_addr = (cp-'h20)*8 + 3.
- TXT_PAUSE=3: 3 frame_starts → greeting=1; after 32*3 frame_starts greeting wraps to 0.
- cp='h10 and cp='h7F → font_addr = glyph_line (glyph 0).
- line_start at T5 of an active sequence → overrun=1; sequence restarts with greet_addr base+0 at T6.
- rst asserted at T12 → load_valid=0 and busy=0 next cycle; greeting=0; no done pulse.
